// File: rtl/bus_status_reg_multi_pkg.sv
// Shared definitions for the status/interrupt register bank: bus request layout,
// register offsets and the address-decode helper.
package bus_status_reg_multi_pkg;

    localparam int unsigned BUS_AW = 32'd32;
    localparam int unsigned BUS_DW = 32'd32;

    localparam logic [31:0] STATUS_OFS  = 32'd0;
    localparam logic [31:0] PENDING_OFS = 32'd4;
    localparam logic [31:0] ENABLE_OFS  = 32'd8;
    localparam logic [31:0] RISE_OFS    = 32'd12;
    localparam logic [31:0] FALL_OFS    = 32'd16;

    typedef struct packed {
        logic [BUS_AW-1:0] addr;
        logic [BUS_DW-1:0] wdata;
        logic              wr;
        logic              rd;
    } bus_req_t;

    // Exact word match: unaligned or neighbouring addresses never alias a register.
    function automatic logic reg_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] ofs);
        return (addr == (base + ofs));
    endfunction

endpackage

// File: rtl/bus_status_reg_multi_if.sv
// Standard register bus: request bundle driven by the master, OR-combinable read data
// returned by each slave.
interface bus_status_reg_multi_if;
    import bus_status_reg_multi_pkg::*;

    bus_req_t          bus_in;
    logic [BUS_DW-1:0] bus_out;

    modport master (output bus_in, input bus_out);
    modport slave  (input bus_in, output bus_out);

endinterface

// File: rtl/bus_status_reg_multi_edge_debounce.sv
// Per-bit stability filter: tracks the latest candidate and counts how long it has
// held. Only built with BUS_STATUS_REG_DEBOUNCE_EN.
`ifdef BUS_STATUS_REG_DEBOUNCE_EN
module bus_status_reg_multi_edge_debounce
    #(
        parameter int   DEBOUNCE_CYCLES = 16,
        parameter logic INIT            = 1'b0
    )
    (
        input  logic bus_clk,
        input  logic bus_reset_l,
        input  logic sample,
        output logic cand,
        output logic stable
    );

    // Counter saturates at DEBOUNCE_CYCLES-1 so the caller updates on the next edge.
    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic        cand_r;
    logic [15:0] cnt_r;

    // Restart on any candidate change, otherwise count up and hold at saturation.
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            cand_r <= INIT;
            cnt_r  <= 16'd0;
        end else if (sample != cand_r) begin
            cand_r <= sample;
            cnt_r  <= 16'd0;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r  <= cnt_r + 16'd1;
        end
    end

    assign cand   = cand_r;
    assign stable = (sample == cand_r) && (cnt_r == CNT_MAX);

endmodule
`endif

// File: rtl/bus_status_reg_multi.sv
// Status/interrupt register bank: synchronised inputs, per-bit edge detection, sticky
// W1C pending, mask and active-low irq. Optional input debounce: BUS_STATUS_REG_DEBOUNCE_EN.
module bus_status_reg_multi
    import bus_status_reg_multi_pkg::*;
    #(
        parameter int                  DATAWIDTH       = 32,
        parameter logic [31:0]         ADDR            = 32'h0000_0000,
        parameter logic [31:0]         OFFSET          = 32'h0000_0000,
        parameter int                  SYNC_STAGES     = 2,
        parameter logic [DATAWIDTH-1:0] INV            = '0,
        parameter logic [DATAWIDTH-1:0] IZ             = '0,
        parameter int                  DEBOUNCE_CYCLES = 16
    )
    (
        input  logic                   bus_clk,
        input  logic                   bus_reset_l,
        bus_status_reg_multi_if.slave  bus,
        input  logic [DATAWIDTH-1:0]   in,
        output logic                   irq_l
    );

    localparam logic [31:0] BASE = ADDR + OFFSET;

    logic [DATAWIDTH-1:0] sync_r [SYNC_STAGES];
    logic [DATAWIDTH-1:0] sync_out_s;
    logic [DATAWIDTH-1:0] filt_s;
    logic [DATAWIDTH-1:0] status_r;
    logic [DATAWIDTH-1:0] pending_r;
    logic [DATAWIDTH-1:0] enable_r;
    logic [DATAWIDTH-1:0] rise_en_r;
    logic [DATAWIDTH-1:0] fall_en_r;
    logic [DATAWIDTH-1:0] ev_s;
    logic [DATAWIDTH-1:0] w1c_s;
    logic [DATAWIDTH-1:0] wdata_s;
    logic                 wr_enable_s;
    logic                 wr_rise_s;
    logic                 wr_fall_s;
    logic [31:0]          rd_mux_s;
    logic [31:0]          rdata_r;

    // Input synchroniser; inversion is applied ahead of the first stage.
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= IZ;
            end
        end else begin
            sync_r[0] <= in ^ INV;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    assign sync_out_s = sync_r[SYNC_STAGES-1];

`ifdef BUS_STATUS_REG_DEBOUNCE_EN
    for (genvar i = 0; i < DATAWIDTH; i++) begin : g_deb
        logic cand_s;
        logic stable_s;

        bus_status_reg_multi_edge_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INIT            (IZ[i])
        ) u_deb (
            .bus_clk     (bus_clk),
            .bus_reset_l (bus_reset_l),
            .sample      (sync_out_s[i]),
            .cand        (cand_s),
            .stable      (stable_s)
        );

        // status only moves once the candidate has been stable long enough
        assign filt_s[i] = stable_s ? cand_s : status_r[i];
    end
`else
    assign filt_s = sync_out_s;
`endif

    // Edges are always judged against the last accepted status value.
    assign ev_s = (filt_s & ~status_r & rise_en_r) | (~filt_s & status_r & fall_en_r);

    // Write decode and read mux.
    always_comb begin
        wdata_s     = bus.bus_in.wdata[DATAWIDTH-1:0];
        w1c_s       = '0;
        wr_enable_s = 1'b0;
        wr_rise_s   = 1'b0;
        wr_fall_s   = 1'b0;
        rd_mux_s    = 32'd0;
        if (bus.bus_in.wr) begin
            wr_enable_s = reg_hit(bus.bus_in.addr, BASE, ENABLE_OFS);
            wr_rise_s   = reg_hit(bus.bus_in.addr, BASE, RISE_OFS);
            wr_fall_s   = reg_hit(bus.bus_in.addr, BASE, FALL_OFS);
            if (reg_hit(bus.bus_in.addr, BASE, PENDING_OFS)) begin
                w1c_s = wdata_s;
            end else begin
                w1c_s = '0;
            end
        end else begin
            w1c_s = '0;
        end
        if (!bus.bus_in.rd) begin
            rd_mux_s = 32'd0;
        end else if (reg_hit(bus.bus_in.addr, BASE, STATUS_OFS)) begin
            rd_mux_s = 32'(status_r);
        end else if (reg_hit(bus.bus_in.addr, BASE, PENDING_OFS)) begin
            rd_mux_s = 32'(pending_r);
        end else if (reg_hit(bus.bus_in.addr, BASE, ENABLE_OFS)) begin
            rd_mux_s = 32'(enable_r);
        end else if (reg_hit(bus.bus_in.addr, BASE, RISE_OFS)) begin
            rd_mux_s = 32'(rise_en_r);
        end else if (reg_hit(bus.bus_in.addr, BASE, FALL_OFS)) begin
            rd_mux_s = 32'(fall_en_r);
        end else begin
            rd_mux_s = 32'd0;
        end
    end

    // Status tracking, sticky pending (a same-cycle event beats W1C) and control regs.
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            status_r  <= IZ;
            pending_r <= '0;
            enable_r  <= '0;
            rise_en_r <= '0;
            fall_en_r <= '0;
        end else begin
            status_r  <= filt_s;
            pending_r <= (pending_r & ~w1c_s) | ev_s;
            if (wr_enable_s) begin
                enable_r <= wdata_s;
            end
            if (wr_rise_s) begin
                rise_en_r <= wdata_s;
            end
            if (wr_fall_s) begin
                fall_en_r <= wdata_s;
            end
        end
    end

    // Registered read data; zero whenever this block is not being read.
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            rdata_r <= 32'd0;
        end else begin
            rdata_r <= rd_mux_s;
        end
    end

    assign bus.bus_out = rdata_r;
    assign irq_l       = ~|(pending_r & enable_r);

endmodule

// File: tb/tb_bus_status_reg_multi.sv
// Scoreboard bench for bus_status_reg_multi: stimulus queues expected read data and
// irq/bus levels; a negedge monitor pops and compares.
module tb_bus_status_reg_multi;
    import bus_status_reg_multi_pkg::*;

    localparam int          DW   = 8;
    localparam int          SYNC = 2;
    localparam int          DEB  = 8;
    localparam logic [31:0] A    = 32'h0000_0100;
    localparam logic [31:0] OF   = 32'h0000_0020;
    localparam logic [31:0] BASE = A + OF;
`ifdef BUS_STATUS_REG_DEBOUNCE_EN
    localparam int LAT = SYNC + 1 + DEB;
`else
    localparam int LAT = SYNC + 1;
`endif

    logic          bus_clk = 1'b0;
    logic          bus_reset_l;
    logic [DW-1:0] in;
    logic          irq_l;
    logic          rd_d = 1'b0;

    bus_status_reg_multi_if bus ();

    bus_status_reg_multi #(
        .DATAWIDTH       (DW),
        .ADDR            (A),
        .OFFSET          (OF),
        .SYNC_STAGES     (SYNC),
        .INV             (8'h80),
        .IZ              (8'h00),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .bus_clk     (bus_clk),
        .bus_reset_l (bus_reset_l),
        .bus         (bus),
        .in          (in),
        .irq_l       (irq_l)
    );

    always #5 bus_clk = ~bus_clk;

    typedef struct { logic [31:0] exp; string name; } rd_exp_t;
    typedef struct { bit is_irq; logic [31:0] exp; string name; } now_exp_t;

    rd_exp_t  rd_q  [$];
    now_exp_t now_q [$];
    int checks = 0;
    int errors = 0;

    initial forever begin
        @(posedge bus_clk);
        rd_d = bus.bus_in.rd;
    end

    // Monitor: read data is due the cycle after a read strobe; level checks are due now.
    initial forever begin
        rd_exp_t  re;
        now_exp_t ne;
        logic [31:0] act;
        @(negedge bus_clk);
        if (rd_d) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read got %h with no expectation", bus.bus_out);
            end else begin
                re = rd_q.pop_front();
                if (bus.bus_out !== re.exp) begin
                    errors++;
                    $display("FAIL %s got %h expected %h", re.name, bus.bus_out, re.exp);
                end
            end
        end
        while (now_q.size() > 0) begin
            ne  = now_q.pop_front();
            act = ne.is_irq ? {31'd0, irq_l} : bus.bus_out;
            checks++;
            if (act !== ne.exp) begin
                errors++;
                $display("FAIL %s got %h expected %h", ne.name, act, ne.exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge bus_clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] ofs, input logic [31:0] d);
        bus.bus_in.addr  = BASE + ofs;
        bus.bus_in.wdata = d;
        bus.bus_in.wr    = 1'b1;
        tick(1);
        bus.bus_in.wr    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        rd_q.push_back('{exp, nm});
        bus.bus_in.addr = addr;
        bus.bus_in.rd   = 1'b1;
        tick(1);
        bus.bus_in.rd   = 1'b0;
    endtask

    task automatic expect_irq(input logic e, input string nm);
        now_q.push_back('{1'b1, {31'd0, e}, nm});
    endtask

    task automatic expect_bus(input logic [31:0] e, input string nm);
        now_q.push_back('{1'b0, e, nm});
    endtask

    initial begin
        bus.bus_in  = '0;
        in          = 8'h80;
        bus_reset_l = 1'b0;
        tick(3);
        expect_irq(1'b1, "reset_irq");
        expect_bus(32'd0, "reset_bus_out");
        tick(1);
        bus_reset_l = 1'b1;
        tick(2);
        rd(BASE + STATUS_OFS,  32'h00, "reset_status");
        rd(BASE + PENDING_OFS, 32'h00, "reset_pending");
        rd(BASE + ENABLE_OFS,  32'h00, "reset_enable");
        rd(BASE + RISE_OFS,    32'h00, "reset_rise");
        rd(BASE + FALL_OFS,    32'h00, "reset_fall");

        // rising edge on bit 0, exact latency
        wr(RISE_OFS, 32'h1);
        wr(ENABLE_OFS, 32'h1);
        in[0] = 1'b1;
        tick(LAT - 1);
        expect_irq(1'b1, "rise_irq_early");
        tick(1);
        expect_irq(1'b0, "rise_irq");
        rd(BASE + STATUS_OFS,  32'h01, "rise_status");
        rd(BASE + PENDING_OFS, 32'h01, "rise_pending");
        wr(PENDING_OFS, 32'h1);
        expect_irq(1'b1, "rise_w1c_irq");
        rd(BASE + PENDING_OFS, 32'h00, "rise_w1c_pending");

        // falling edge on bit 2, masked then unmasked
        wr(RISE_OFS, 32'h0);
        wr(FALL_OFS, 32'h4);
        wr(ENABLE_OFS, 32'h0);
        in[2] = 1'b1;
        tick(LAT + 2);
        rd(BASE + PENDING_OFS, 32'h00, "fall_no_rise_event");
        rd(BASE + STATUS_OFS,  32'h05, "fall_status_high");
        in[2] = 1'b0;
        tick(LAT + 2);
        rd(BASE + PENDING_OFS, 32'h04, "fall_pending");
        rd(BASE + STATUS_OFS,  32'h01, "fall_status_low");
        expect_irq(1'b1, "fall_masked_irq");
        wr(ENABLE_OFS, 32'h4);
        expect_irq(1'b0, "unmask_irq");
        wr(PENDING_OFS, 32'h4);
        expect_irq(1'b1, "fall_w1c_irq");

        // W1C lands on the same edge as a new rise on bit 3
        wr(RISE_OFS, 32'h8);
        in[3] = 1'b1;
        tick(LAT - 1);
        wr(PENDING_OFS, 32'h8);
        rd(BASE + PENDING_OFS, 32'h08, "collision_set_wins");
        rd(BASE + STATUS_OFS,  32'h09, "collision_status");
        wr(PENDING_OFS, 32'h8);
        rd(BASE + PENDING_OFS, 32'h00, "collision_clear_after");

        // inversion on bit 7
        in[7] = 1'b0;
        tick(LAT + 1);
        rd(BASE + STATUS_OFS,  32'h89, "inv_status");
        rd(BASE + PENDING_OFS, 32'h00, "inv_no_event");
        wr(FALL_OFS, 32'h80);
        in[7] = 1'b1;
        tick(LAT + 1);
        rd(BASE + STATUS_OFS,  32'h09, "inv_fall_status");
        rd(BASE + PENDING_OFS, 32'h80, "inv_fall_pending");

        // mode writes alone raise nothing; decode and read-only checks
        wr(RISE_OFS, 32'hFF);
        wr(FALL_OFS, 32'hFF);
        tick(2);
        rd(BASE + PENDING_OFS, 32'h80, "mode_change_no_event");
        wr(STATUS_OFS, 32'hFF);
        rd(BASE + STATUS_OFS,  32'h09, "status_write_ignored");
        rd(BASE + 32'd20,      32'h00, "unmapped_read");
        rd(BASE + 32'd2,       32'h00, "unaligned_read");
        rd(A + ENABLE_OFS,     32'h00, "offset_decode");
        rd(BASE + ENABLE_OFS,  32'h04, "enable_readback");

`ifdef BUS_STATUS_REG_DEBOUNCE_EN
        // short glitch is filtered, a stable change gets through with added latency
        in[1] = 1'b1;
        tick(5);
        in[1] = 1'b0;
        tick(20);
        rd(BASE + STATUS_OFS,  32'h09, "deb_glitch_status");
        rd(BASE + PENDING_OFS, 32'h80, "deb_glitch_pending");
        wr(ENABLE_OFS, 32'h2);
        in[1] = 1'b1;
        tick(LAT - 1);
        expect_irq(1'b1, "deb_irq_early");
        tick(1);
        expect_irq(1'b0, "deb_irq");
        rd(BASE + STATUS_OFS,  32'h0B, "deb_status");
        rd(BASE + PENDING_OFS, 32'h82, "deb_pending");
`endif

        // asynchronous reset in the middle of a cycle
        wr(ENABLE_OFS, 32'h80);
        expect_irq(1'b0, "pre_reset_irq");
        tick(1);
        #2;
        bus_reset_l = 1'b0;
        #1;
        expect_irq(1'b1, "async_reset_irq");
        tick(2);
        bus_reset_l = 1'b1;
        rd(BASE + STATUS_OFS,  32'h00, "post_reset_status");
        rd(BASE + PENDING_OFS, 32'h00, "post_reset_pending");
        rd(BASE + ENABLE_OFS,  32'h00, "post_reset_enable");
        rd(BASE + FALL_OFS,    32'h00, "post_reset_fall");
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_status_reg_multi.md
Name: bus_status_reg_multi

Overview:
- Parametrised software status/interrupt register block on the team's standard register bus.
- Samples DATAWIDTH asynchronous inputs through a configurable-depth synchronizer and exposes them as a status word.
- Each bit can raise an interrupt on a rising edge, a falling edge or both, selected per bit by software.
- Pending bits are sticky and write-1-to-clear. Maskable interrupt output irq_l. Used for GPIO/status banks feeding the CPU interrupt controller.

Parameters:
- DATAWIDTH, 32, number of input bits (1..32).
- ADDR, 0, base byte address of the 5-register window.
- OFFSET, 0, added to ADDR for decode.
- SYNC_STAGES, 2, synchronizer depth (2..4).
- INV, 0, per-bit input inversion mask applied before synchronizing.
- IZ, 0, reset value of the synchronizer and status flops.
- DEBOUNCE_CYCLES, 16, stable-sample count; used only with the optional feature (1..65535).

Ports:
- bus_clk  input  1  bus clock.
- bus_reset_l  input  1  reset, asynchronous, active-low.
- bus_in  input  BUS_IN_WIDTH  standard register bus request: address, write data, write strobe, read strobe.
- bus_out  output  BUS_OUT_WIDTH  read data; all-zero when not addressed (OR-combinable).
- in  input  DATAWIDTH  asynchronous status inputs.
- irq_l  output  1  active-low interrupt, ~|(pending & enable).

Behaviour:
- Register map (byte offsets from ADDR+OFFSET):
  - +0 STATUS: RO, synchronized value.
  - +4 PENDING: read; write-1-to-clear.
  - +8 ENABLE: RW.
  - +12 RISE_EN: RW.
  - +16 FALL_EN: RW.
  - Writes to STATUS are ignored. Unused upper bits read 0.
- Reset:
  - Sync chain and STATUS = IZ.
  - PENDING, ENABLE, RISE_EN and FALL_EN = 0.
  - irq_l = 1, bus_out = 0.
- Sync: stage0 <= in^INV; stage k <= stage k-1. sync_out = stage SYNC_STAGES-1.
- Event per bit: rise = sync_out & ~status_q; fall = ~sync_out & status_q. ev = (rise & RISE_EN) | (fall & FALL_EN).
- Each clock:
  - status_q <= sync_out.
  - pending <= (pending & ~w1c_mask) | ev.
- Latency:
  - An input change is visible in STATUS, and sets PENDING, SYNC_STAGES+1 edges after the first sampling edge.
  - irq_l falls in the same cycle PENDING&ENABLE becomes non-zero. irq_l is combinational from flops only, with no extra latency.
- Simultaneous events:
  - W1C and a new event on the same bit in the same cycle: set wins, bit stays 1.
  - W1C on a bit with no event clears it.
- Toggling inputs: an input pulse shorter than one bus_clk may be lost. That is acceptable, and no event is generated for a lost pulse.
- Mode changes: writing RISE_EN/FALL_EN does not generate events by itself. Edges are detected only relative to status_q.
- ENABLE affects irq_l only. PENDING still latches while masked, so unmasking a pending bit asserts irq_l the next cycle after the write.
- Reads: registered; read data appears per the standard bus read timing (one cycle after the read strobe). Address decode is exact word match.
- Reset mid-operation: all state returns to reset values asynchronously. In-flight edges are discarded.

Optional Feature:
- Macro BUS_STATUS_REG_DEBOUNCE_EN.
- When defined:
  - A per-bit counter sits between sync_out and status_q.
  - The candidate value must stay constant for DEBOUNCE_CYCLES consecutive clocks before status_q updates and an edge event fires.
  - Any change of the candidate restarts its counter at 0. The counter saturates and holds while stable.
  - Added latency: DEBOUNCE_CYCLES cycles.
- When undefined: status_q follows sync_out directly as above, with no counters synthesized.

Decomposition:
- Shared package/include: register offset constants (STATUS_OFS=0, PENDING_OFS=4, ENABLE_OFS=8, RISE_OFS=12, FALL_OFS=16).
- Sub-module edge_debounce (one per bit, generate loop): the counter plus stable flag, compiled only under BUS_STATUS_REG_DEBOUNCE_EN.
- Bus decode/readback is inline, reusing the standard bus decl include.

Test Plan:
- Reset check: reset with IZ=0 -> all five registers read 0, irq_l=1.
- Rising edge:
  - Setup: RISE_EN=0x1, ENABLE=0x1.
  - Stimulus: drive in[0] 0->1.
  - Required: STATUS=0x1 and PENDING=0x1 exactly SYNC_STAGES+1 edges later, with irq_l=0 the same cycle.
  - Then write PENDING=0x1 -> irq_l=1 next cycle.
- Falling edge:
  - Setup: FALL_EN=0x4, RISE_EN=0.
  - Stimulus: in[2] 0->1->0.
  - Required: PENDING=0x4 set only on the fall. With ENABLE=0, irq_l stays 1; writing ENABLE=0x4 -> irq_l=0.
- Collision: W1C of bit 3 issued in the same cycle a new rising edge on bit 3 reaches status -> PENDING bit 3 remains 1.
- Inversion: INV=0x80, in[7] held 0 -> STATUS=0x80 after sync. Driving in[7]=1 with FALL_EN=0x80 -> PENDING=0x80.
- Debounce (macro defined, DEBOUNCE_CYCLES=8):
  - 5-cycle glitch on in[1] -> no STATUS change, PENDING=0.
  - 8-cycle-stable change -> STATUS and PENDING update SYNC_STAGES+1+8 edges after the change.
